// File: rtl/fifo_pkg.sv
// Shared Gray/binary helpers and default sizing for the async FIFO pointer logic.
// Latency: none, pure functions and constants.
// Backpressure: not applicable.
//
// Used by both the write-side full logic and the read-side empty logic.
// The functions work on a fixed wide vector; callers zero-extend their
// ADDRSIZE+1 bit pointers and keep the low bits, so one definition serves
// every pointer width below PTR_MAX_W.
package fifo_pkg;

  localparam int DEF_ADDRSIZE = 4;
  localparam int DEPTH        = 2 ** DEF_ADDRSIZE;
  localparam int PTR_MAX_W    = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down: bit i becomes the XOR of bits [W-1:i].
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = g;
    for (int s = 1; s < PTR_MAX_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_level_if.sv
// Write-domain bus of the async FIFO pointer block.
// Latency: n/a (signal bundle only).
// Backpressure: writer must honour wfull; a write while full is dropped and flagged.
//
// Ports: winc/wclr_ovf/wq2_rptr flow into the pointer logic; waddr, wptr,
// wfull, walmost_full, wcount and woverflow flow out of it.
interface wptr_full_level_if #(
  parameter int ADDRSIZE = 4
);

  logic                winc;
  logic                wclr_ovf;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wcount;
  logic                woverflow;

  // Writer / synchronizer side.
  modport master (
    output winc, wclr_ovf, wq2_rptr,
    input  waddr, wptr, wfull, walmost_full, wcount, woverflow
  );

  // Pointer and flag logic.
  modport slave (
    input  winc, wclr_ovf, wq2_rptr,
    output waddr, wptr, wfull, walmost_full, wcount, woverflow
  );

endinterface

// File: rtl/wptr_full_level_gray2bin.sv
// Gray-to-binary conversion of the synchronized read pointer.
// Latency: combinational.
// Backpressure: not applicable.
//
// Ports: gray (W bits in), bin (W bits out).
module wptr_full_level_gray2bin
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  ptr_max_t           bin_full;
  logic [PTR_MAX_W-1:W] unused_bin_hi;

  assign bin_full      = gray2bin(ptr_max_t'(gray));
  assign bin           = bin_full[W-1:0];
  // Zero-extended input, so these upper bits are always zero.
  assign unused_bin_hi = bin_full[PTR_MAX_W-1:W];

endmodule

// File: rtl/wptr_full_level.sv
// Write pointer, full / almost-full / fill-level / sticky overflow for the async FIFO.
// Latency: all outputs registered; one wclk edge from winc or wq2_rptr change to outputs.
// Backpressure: wfull blocks writes; a write attempted while full is dropped and sets woverflow.
//
// Ports: wclk, wrst_n (async active-low), w (slave modport: winc, wclr_ovf,
// wq2_rptr in; waddr, wptr, wfull, walmost_full, wcount, woverflow out).
module wptr_full_level
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  wptr_full_level_if.slave  w
);

  localparam int FIFO_DEPTH = 2 ** ADDRSIZE;

  typedef logic [ADDRSIZE:0] ptr_t;

  localparam ptr_t AF_THRESH = ptr_t'(FIFO_DEPTH - AF_MARGIN);

  ptr_t wbin;
  ptr_t wptr_r;
  ptr_t wcount_r;
  logic wfull_r;
  logic walmost_full_r;
  logic woverflow_r;

  logic     wen;
  ptr_t     wbinnext;
  ptr_t     wgraynext;
  ptr_t     rq2bin;
  ptr_t     wcount_next;
  ptr_t     full_cmp;
  logic     wfull_val;
  logic     walmost_full_val;
  logic     woverflow_next;
  ptr_max_t gray_full;
  logic [PTR_MAX_W-1:ADDRSIZE+1] unused_gray_hi;

  assign wen       = w.winc & ~wfull_r;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign gray_full = bin2gray(ptr_max_t'(wbinnext));
  assign wgraynext = gray_full[ADDRSIZE:0];
  // Zero-extended input, so these upper bits are always zero.
  assign unused_gray_hi = gray_full[PTR_MAX_W-1:ADDRSIZE+1];

  wptr_full_level_gray2bin #(
    .W (ADDRSIZE + 1)
  ) u_rq2bin (
    .gray (w.wq2_rptr),
    .bin  (rq2bin)
  );

  // Full when the write pointer is exactly one lap ahead: in Gray code that
  // means the top two bits are inverted and the rest match.
  assign full_cmp  = {~w.wq2_rptr[ADDRSIZE:ADDRSIZE-1], w.wq2_rptr[ADDRSIZE-2:0]};
  assign wfull_val = (wgraynext == full_cmp);

  // The read pointer is stale, so this can only over-estimate the level.
  assign wcount_next      = wbinnext - rq2bin;
  assign walmost_full_val = (wcount_next >= AF_THRESH);

  // Set has priority over clear so an overflow in the clearing cycle is kept.
  assign woverflow_next = (w.winc & wfull_r) | (woverflow_r & ~w.wclr_ovf);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin           <= '0;
      wptr_r         <= '0;
      wcount_r       <= '0;
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      woverflow_r    <= 1'b0;
    end else begin
      wbin           <= wbinnext;
      wptr_r         <= wgraynext;
      wcount_r       <= wcount_next;
      wfull_r        <= wfull_val;
      walmost_full_r <= walmost_full_val;
      woverflow_r    <= woverflow_next;
    end
  end

  assign w.waddr        = wbin[ADDRSIZE-1:0];
  assign w.wptr         = wptr_r;
  assign w.wcount       = wcount_r;
  assign w.wfull        = wfull_r;
  assign w.walmost_full = walmost_full_r;
  assign w.woverflow    = woverflow_r;

endmodule
